// File: rtl/vga_timing_detector.sv
// Sink-side video timing monitor: measures line/frame geometry, recovers pixel
// coordinates and declares lock once consecutive frames agree.
module vga_timing_detector #(
    parameter logic [10:0] EXP_H_TOTAL = 11'd1650,
    parameter logic [10:0] EXP_H_DISP  = 11'd1280,
    parameter logic [10:0] EXP_V_TOTAL = 11'd750,
    parameter logic [10:0] EXP_V_DISP  = 11'd720,
    parameter logic        HS_POL      = 1'b1,
    parameter logic        VS_POL      = 1'b1,
    parameter logic [2:0]  LOCK_FRAMES = 3'd2
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        video_hs,
    input  logic        video_vs,
    input  logic        video_en,
    output logic        pix_valid,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        frame_start,
    output logic [10:0] h_total_meas,
    output logic [10:0] h_disp_meas,
    output logic [10:0] v_total_meas,
    output logic [10:0] v_disp_meas,
    output logic        locked,
    output logic        fmt_ok,
    output logic        no_signal
);

    typedef enum logic [1:0] {
        NO_SIGNAL = 2'd0,
        ACQUIRE   = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    localparam logic [10:0] CNT_MAX = 11'd2047;

    state_t      state;
    state_t      state_nxt;
    logic        hs_q;
    logic        hs_q1;
    logic        vs_q;
    logic        vs_q1;
    logic        en_q;
    logic        en_q1;
    logic        hs_rise;
    logic        vs_rise;
    logic        en_fall;
    logic [10:0] h_cnt;
    logic [10:0] h_cnt_nxt;
    logic        h_timeout;
    logic [10:0] en_cnt;
    logic [10:0] line_cnt;
    logic [10:0] act_cnt;
    logic        frame_seen;
    logic        have_prev;
    logic        frame_done;
    logic        frame_match;
    logic [10:0] prev_h_total;
    logic [10:0] prev_h_disp;
    logic [10:0] prev_v_total;
    logic [10:0] prev_v_disp;
    logic [2:0]  match_cnt;
    logic [2:0]  match_nxt;

    // Sync inputs are normalised so that 1 always means "active level".
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            hs_q  <= 1'b0;
            hs_q1 <= 1'b0;
            vs_q  <= 1'b0;
            vs_q1 <= 1'b0;
            en_q  <= 1'b0;
            en_q1 <= 1'b0;
        end else begin
            hs_q  <= (video_hs == HS_POL);
            hs_q1 <= hs_q;
            vs_q  <= (video_vs == VS_POL);
            vs_q1 <= vs_q;
            en_q  <= video_en;
            en_q1 <= en_q;
        end
    end

    assign hs_rise = hs_q & ~hs_q1;
    assign vs_rise = vs_q & ~vs_q1;
    assign en_fall = en_q1 & ~en_q;

    // A saturated line counter doubles as the loss-of-signal watchdog.
    always_comb begin
        h_cnt_nxt = h_cnt;
        if (hs_rise) begin
            h_cnt_nxt = 11'd0;
        end else if (h_cnt != CNT_MAX) begin
            h_cnt_nxt = h_cnt + 11'd1;
        end
        h_timeout = !hs_rise && (h_cnt_nxt == CNT_MAX);
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            h_cnt    <= 11'd0;
            en_cnt   <= 11'd0;
            line_cnt <= 11'd0;
            act_cnt  <= 11'd0;
        end else begin
            h_cnt <= h_cnt_nxt;

            if (en_fall) begin
                en_cnt <= 11'd0;
            end else if (en_q && en_cnt != CNT_MAX) begin
                en_cnt <= en_cnt + 11'd1;
            end

            // A line starting on the frame edge belongs to the new frame.
            if (vs_rise) begin
                line_cnt <= hs_rise ? 11'd1 : 11'd0;
            end else if (hs_rise && line_cnt != CNT_MAX) begin
                line_cnt <= line_cnt + 11'd1;
            end

            if (vs_rise) begin
                act_cnt <= 11'd0;
            end else if (en_fall && act_cnt != CNT_MAX) begin
                act_cnt <= act_cnt + 11'd1;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            h_total_meas <= 11'd0;
            h_disp_meas  <= 11'd0;
            v_total_meas <= 11'd0;
            v_disp_meas  <= 11'd0;
        end else if (h_timeout) begin
            h_total_meas <= 11'd0;
            h_disp_meas  <= 11'd0;
            v_total_meas <= 11'd0;
            v_disp_meas  <= 11'd0;
        end else begin
            if (hs_rise && state != NO_SIGNAL) begin
                h_total_meas <= h_cnt + 11'd1;
            end
            if (en_fall) begin
                h_disp_meas <= en_cnt;
            end
            if (frame_done) begin
                v_total_meas <= line_cnt;
                v_disp_meas  <= act_cnt;
            end
        end
    end

    assign frame_done  = vs_rise && frame_seen;
    assign frame_match = have_prev
                         && (h_total_meas == prev_h_total)
                         && (h_disp_meas  == prev_h_disp)
                         && (line_cnt     == prev_v_total)
                         && (act_cnt      == prev_v_disp);

    // match_cnt is the length of the current run of identical frames, so a
    // differing frame starts a fresh run of one.
    always_comb begin
        state_nxt = state;
        match_nxt = match_cnt;
        case (state)
            NO_SIGNAL: begin
                match_nxt = 3'd0;
                if (hs_rise) begin
                    state_nxt = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (frame_done) begin
                    if (frame_match) begin
                        match_nxt = (match_cnt == 3'd7) ? 3'd7 : match_cnt + 3'd1;
                    end else begin
                        match_nxt = 3'd1;
                    end
                    if (match_nxt >= LOCK_FRAMES) begin
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (frame_done && !frame_match) begin
                    state_nxt = ACQUIRE;
                    match_nxt = 3'd1;
                end
            end
            default: begin
                state_nxt = NO_SIGNAL;
                match_nxt = 3'd0;
            end
        endcase
        if (h_timeout) begin
            state_nxt = NO_SIGNAL;
            match_nxt = 3'd0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            state        <= NO_SIGNAL;
            match_cnt    <= 3'd0;
            frame_seen   <= 1'b0;
            have_prev    <= 1'b0;
            prev_h_total <= 11'd0;
            prev_h_disp  <= 11'd0;
            prev_v_total <= 11'd0;
            prev_v_disp  <= 11'd0;
            locked       <= 1'b0;
            fmt_ok       <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            state       <= state_nxt;
            match_cnt   <= match_nxt;
            frame_start <= vs_rise;
            locked      <= (state_nxt == LOCKED);
            fmt_ok      <= locked
                           && (h_total_meas == EXP_H_TOTAL)
                           && (h_disp_meas  == EXP_H_DISP)
                           && (v_total_meas == EXP_V_TOTAL)
                           && (v_disp_meas  == EXP_V_DISP);

            // The first frame edge after acquisition only opens a frame.
            if (state_nxt == NO_SIGNAL) begin
                frame_seen <= 1'b0;
                have_prev  <= 1'b0;
            end else begin
                if (vs_rise && state != NO_SIGNAL) begin
                    frame_seen <= 1'b1;
                end
                if (frame_done) begin
                    have_prev    <= 1'b1;
                    prev_h_total <= h_total_meas;
                    prev_h_disp  <= h_disp_meas;
                    prev_v_total <= line_cnt;
                    prev_v_disp  <= act_cnt;
                end
            end
        end
    end

    assign pix_valid = en_q;
    assign pix_x     = en_cnt;
    assign pix_y     = act_cnt;
    assign no_signal = (state == NO_SIGNAL);

endmodule

// File: tb/tb_vga_timing_detector.sv
// Directed bench for vga_timing_detector using a scaled-down 20x10 raster
// (12x6 active); a second instance sees active-low hsync.
module tb_vga_timing_detector;

    localparam int HT = 20;
    localparam int HD = 12;
    localparam int VT = 10;
    localparam int VD = 6;

    logic        pixel_clk = 1'b0;
    logic        rst_n     = 1'b0;
    logic        video_hs  = 1'b0;
    logic        video_vs  = 1'b0;
    logic        video_en  = 1'b0;
    logic        video_hs_n;

    logic        pix_valid, frame_start, locked, fmt_ok, no_signal;
    logic [10:0] pix_x, pix_y, h_total_meas, h_disp_meas, v_total_meas, v_disp_meas;
    logic        pix_valid_n, frame_start_n, locked_n, fmt_ok_n, no_signal_n;
    logic [10:0] pix_x_n, pix_y_n, h_total_n, h_disp_n, v_total_n, v_disp_n;

    int checks   = 0;
    int failures = 0;

    logic        obs_fs0, obs_fs1, obs_fs2, obs_lk1, obs_fmt1, obs_fmt2, obs_lkn1;
    logic [69:0] obs_rst_vec;
    logic        obs_rst_ns;
    int          pix_err, err_x, err_y, last_x, last_y;

    assign video_hs_n = ~video_hs;

    always #5 pixel_clk = ~pixel_clk;

    vga_timing_detector #(
        .EXP_H_TOTAL(11'd20), .EXP_H_DISP(11'd12), .EXP_V_TOTAL(11'd10),
        .EXP_V_DISP(11'd6), .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(3'd2)
    ) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .video_hs(video_hs), .video_vs(video_vs),
        .video_en(video_en), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .h_total_meas(h_total_meas), .h_disp_meas(h_disp_meas),
        .v_total_meas(v_total_meas), .v_disp_meas(v_disp_meas), .locked(locked),
        .fmt_ok(fmt_ok), .no_signal(no_signal)
    );

    vga_timing_detector #(
        .EXP_H_TOTAL(11'd20), .EXP_H_DISP(11'd12), .EXP_V_TOTAL(11'd10),
        .EXP_V_DISP(11'd6), .HS_POL(1'b0), .VS_POL(1'b1), .LOCK_FRAMES(3'd2)
    ) dut_n (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .video_hs(video_hs_n), .video_vs(video_vs),
        .video_en(video_en), .pix_valid(pix_valid_n), .pix_x(pix_x_n), .pix_y(pix_y_n),
        .frame_start(frame_start_n), .h_total_meas(h_total_n), .h_disp_meas(h_disp_n),
        .v_total_meas(v_total_n), .v_disp_meas(v_disp_n), .locked(locked_n),
        .fmt_ok(fmt_ok_n), .no_signal(no_signal_n)
    );

    task automatic step(input logic hs, input logic vs, input logic en);
        video_hs = hs;
        video_vs = vs;
        video_en = en;
        @(posedge pixel_clk);
        #1;
    endtask

    // One frame: active lines first, hsync at pixels HD+2..HD+4, vsync on lines VD+1..VD+2.
    task automatic send_frame(input int htot, input bit chk_pix, input int rst_line);
        pix_err = 0;
        last_x  = -1;
        last_y  = -1;
        for (int y = 0; y < VT; y++) begin
            for (int x = 0; x < htot; x++) begin
                logic en, hs, vs;
                en = (y < VD) && (x < HD);
                hs = (x >= HD + 2) && (x <= HD + 4);
                vs = (y == VD + 1) || (y == VD + 2);
                if (y == rst_line && x == 5) begin
                    rst_n = 1'b0;
                    step(hs, vs, en);
                    obs_rst_vec = {pix_valid, pix_x, pix_y, frame_start, h_total_meas,
                                   h_disp_meas, v_total_meas, v_disp_meas, locked, fmt_ok};
                    obs_rst_ns  = no_signal;
                    rst_n = 1'b1;
                end else begin
                    step(hs, vs, en);
                end
                if (y == VD + 1) begin
                    if (x == 0) obs_fs0 = frame_start;
                    if (x == 1) begin
                        obs_fs1  = frame_start;
                        obs_lk1  = locked;
                        obs_lkn1 = locked_n;
                        obs_fmt1 = fmt_ok;
                    end
                    if (x == 2) begin
                        obs_fs2  = frame_start;
                        obs_fmt2 = fmt_ok;
                    end
                end
                if (chk_pix) begin
                    if (pix_valid !== en || (en && (pix_x !== 11'(x) || pix_y !== 11'(y)))) begin
                        if (pix_err == 0) begin
                            err_x = x;
                            err_y = y;
                        end
                        pix_err++;
                    end
                    if (pix_valid === 1'b1) begin
                        last_x = int'(pix_x);
                        last_y = int'(pix_y);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({pix_valid, pix_x, pix_y, frame_start} !== 24'd0) begin
            failures++;
            $display("[TB] FAIL reset_pix: got %0h expected 0", {pix_valid, pix_x, pix_y, frame_start});
        end
        checks++;
        if ({h_total_meas, h_disp_meas, v_total_meas, v_disp_meas} !== 44'd0) begin
            failures++;
            $display("[TB] FAIL reset_meas: got %0h expected 0",
                     {h_total_meas, h_disp_meas, v_total_meas, v_disp_meas});
        end
        checks++;
        if ({locked, fmt_ok, no_signal} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL reset_status: got %b expected 001", {locked, fmt_ok, no_signal});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lock_sequence();
        send_frame(HT, 1'b0, -1);
        checks++;
        if ({h_total_meas, h_disp_meas, v_total_meas} !== {11'd20, 11'd12, 11'd0}) begin
            failures++;
            $display("[TB] FAIL first_frame_meas: got %0d/%0d/%0d expected 20/12/0",
                     h_total_meas, h_disp_meas, v_total_meas);
        end
        checks++;
        if (no_signal !== 1'b0) begin
            failures++;
            $display("[TB] FAIL acquire_no_signal: got %b expected 0", no_signal);
        end
        send_frame(HT, 1'b0, -1);
        checks++;
        if ({v_total_meas, v_disp_meas} !== {11'd10, 11'd6}) begin
            failures++;
            $display("[TB] FAIL v_meas: got %0d/%0d expected 10/6", v_total_meas, v_disp_meas);
        end
        checks++;
        if (obs_lk1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL early_lock: got %b expected 0", obs_lk1);
        end
        send_frame(HT, 1'b0, -1);
        checks++;
        if ({obs_fs0, obs_fs1, obs_fs2} !== 3'b010) begin
            failures++;
            $display("[TB] FAIL frame_start_pulse: got %b expected 010", {obs_fs0, obs_fs1, obs_fs2});
        end
        checks++;
        if ({obs_lk1, obs_fmt1, obs_fmt2} !== 3'b101) begin
            failures++;
            $display("[TB] FAIL lock_fmt_timing: got %b expected 101", {obs_lk1, obs_fmt1, obs_fmt2});
        end
        checks++;
        if ({obs_lkn1, h_total_n, h_disp_n, v_total_n, v_disp_n, fmt_ok_n}
            !== {1'b1, 11'd20, 11'd12, 11'd10, 11'd6, 1'b1}) begin
            failures++;
            $display("[TB] FAIL hs_pol_low: got lk=%b %0d/%0d/%0d/%0d fmt=%b expected 1 20/12/10/6 1",
                     obs_lkn1, h_total_n, h_disp_n, v_total_n, v_disp_n, fmt_ok_n);
        end
    endtask

    task automatic test_pixels();
        send_frame(HT, 1'b1, -1);
        checks++;
        if (pix_err !== 0) begin
            failures++;
            $display("[TB] FAIL pix_coords: got %0d bad pixels (first x=%0d y=%0d) expected 0",
                     pix_err, err_x, err_y);
        end
        checks++;
        if (last_x !== HD - 1 || last_y !== VD - 1) begin
            failures++;
            $display("[TB] FAIL last_pixel: got (%0d,%0d) expected (11,5)", last_x, last_y);
        end
        checks++;
        if ({locked, fmt_ok} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL stay_locked: got %b expected 11", {locked, fmt_ok});
        end
    endtask

    task automatic test_relock();
        send_frame(HT + 1, 1'b0, -1);
        checks++;
        if ({obs_lk1, obs_fmt2} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL unlock_on_change: got %b expected 00", {obs_lk1, obs_fmt2});
        end
        checks++;
        if (h_total_meas !== 11'd21) begin
            failures++;
            $display("[TB] FAIL long_line_meas: got %0d expected 21", h_total_meas);
        end
        send_frame(HT, 1'b0, -1);
        checks++;
        if (obs_lk1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL relock_too_early: got %b expected 0", obs_lk1);
        end
        send_frame(HT, 1'b0, -1);
        checks++;
        if ({obs_lk1, obs_fmt2} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL relock: got %b expected 11", {obs_lk1, obs_fmt2});
        end
    endtask

    task automatic test_no_signal();
        repeat (2030) step(1'b0, 1'b0, 1'b0);
        checks++;
        if (no_signal !== 1'b0) begin
            failures++;
            $display("[TB] FAIL no_signal_early: got %b expected 0", no_signal);
        end
        repeat (70) step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({no_signal, no_signal_n, locked, fmt_ok} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL no_signal_state: got %b expected 1100",
                     {no_signal, no_signal_n, locked, fmt_ok});
        end
        checks++;
        if ({h_total_meas, h_disp_meas, v_total_meas, v_disp_meas} !== 44'd0) begin
            failures++;
            $display("[TB] FAIL no_signal_meas: got %0d/%0d/%0d/%0d expected 0/0/0/0",
                     h_total_meas, h_disp_meas, v_total_meas, v_disp_meas);
        end
    endtask

    task automatic test_reset_midframe();
        send_frame(HT, 1'b0, 3);
        checks++;
        if ({obs_rst_vec, obs_rst_ns} !== {70'd0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL midframe_reset: got %0h/%b expected 0/1", obs_rst_vec, obs_rst_ns);
        end
        checks++;
        if ({locked, v_total_meas} !== {1'b0, 11'd0}) begin
            failures++;
            $display("[TB] FAIL post_reset_frame: got lk=%b vt=%0d expected 0/0", locked, v_total_meas);
        end
        send_frame(HT, 1'b0, -1);
        checks++;
        if ({obs_lk1, v_total_meas, v_disp_meas} !== {1'b0, 11'd10, 11'd6}) begin
            failures++;
            $display("[TB] FAIL post_reset_second: got lk=%b %0d/%0d expected 0 10/6",
                     obs_lk1, v_total_meas, v_disp_meas);
        end
        send_frame(HT, 1'b0, -1);
        checks++;
        if ({obs_lk1, obs_fmt2} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL post_reset_relock: got %b expected 11", {obs_lk1, obs_fmt2});
        end
    endtask

    initial begin
        test_reset();
        test_lock_sequence();
        test_pixels();
        test_relock();
        test_no_signal();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
